// File: rtl/os_ctrl_pkg.sv
// rtl/os_ctrl_pkg.sv - shared types and helpers for the output-stationary feed controller
// Contents: os_feed_state_t FSM encoding, os_drain_cycles(), os_tile_count().
package os_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } os_feed_state_t;

    // N-1 cycles of operand skew plus N cycles of propagation through the array.
    function automatic int os_drain_cycles(input int n);
        return 2 * n - 1;
    endfunction

    // Number of NxN output tiles in an MxM product.
    function automatic int os_tile_count(input int m, input int n);
        return (m / n) * (m / n);
    endfunction

endpackage

// File: rtl/os_feed_ctrl.sv
// rtl/os_feed_ctrl.sv - tile sequencer for the systolic array operand-read path
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              run request, sampled only in IDLE
//   stall              freezes operand issue while in FEED
//   row                reduction index k to the read-address generator
//   column             tile column index to the read-address generator
//   rd_en              read enable to the read-address generator
//   pe_init            accumulator clear, coincident with the k=0 issue of a tile
//   tile_row           tile row index (status / B-side controller)
//   tile_done          one-cycle pulse, tile results valid in the array
//   busy               run in progress
//   done               one-cycle pulse, whole product complete
module os_feed_ctrl
    import os_ctrl_pkg::*;
#(
    parameter int D_W = 8,
    parameter int N   = 3,
    parameter int M   = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stall,
    output logic [$clog2(M)-1:0]      row,
    output logic [$clog2(M/N)-1:0]    column,
    output logic                      rd_en,
    output logic                      pe_init,
    output logic [$clog2(M/N)-1:0]    tile_row,
    output logic                      tile_done,
    output logic                      busy,
    output logic                      done
);

    localparam int K_W       = $clog2(M);
    localparam int T_W       = $clog2(M / N);
    localparam int DRAIN_CYC = os_drain_cycles(N);
    localparam int DC_W      = $clog2(DRAIN_CYC + 1);

    localparam logic [K_W-1:0]  K_LAST = K_W'(M - 1);
    localparam logic [T_W-1:0]  T_LAST = T_W'(M / N - 1);
    localparam logic [DC_W-1:0] D_LAST = DC_W'(DRAIN_CYC - 1);

    // Elaboration-time guard on the tiling geometry; D_W only travels with the datapath.
    if (D_W < 1 || (M % N) != 0 || os_tile_count(M, N) < 4) begin : g_param_check
        $error("os_feed_ctrl: need D_W>=1, M%%N==0 and M/N>=2");
    end

    os_feed_state_t   state, state_d;
    logic [K_W-1:0]   k, k_d;
    logic [DC_W-1:0]  dcnt, dcnt_d;
    logic [K_W-1:0]   row_d;
    logic [T_W-1:0]   col_d, trow_d;
    logic             rd_en_d, pe_init_d, tile_done_d, busy_d, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            dcnt      <= '0;
            row       <= '0;
            column    <= '0;
            tile_row  <= '0;
            rd_en     <= 1'b0;
            pe_init   <= 1'b0;
            tile_done <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            k         <= k_d;
            dcnt      <= dcnt_d;
            row       <= row_d;
            column    <= col_d;
            tile_row  <= trow_d;
            rd_en     <= rd_en_d;
            pe_init   <= pe_init_d;
            tile_done <= tile_done_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Next-state and next-output logic; every output is registered above, so
    // the values computed here appear one edge after the state that produced them.
    always_comb begin
        state_d     = state;
        k_d         = k;
        dcnt_d      = dcnt;
        row_d       = row;
        col_d       = column;
        trow_d      = tile_row;
        rd_en_d     = 1'b0;
        pe_init_d   = 1'b0;
        tile_done_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state)
            IDLE: begin
                k_d    = '0;
                dcnt_d = '0;
                row_d  = '0;
                col_d  = '0;
                trow_d = '0;
                if (start) begin
                    state_d = FEED;
                end
            end

            FEED: begin
                busy_d = 1'b1;
                // row tracks the pending k, so during a stall it shows the held index.
                row_d  = k;
                if (!stall) begin
                    rd_en_d   = 1'b1;
                    // A stall on k=0 lands here later, which is what defers pe_init.
                    pe_init_d = (k == '0);
                    if (k == K_LAST) begin
                        k_d     = '0;
                        dcnt_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        k_d = k + 1'b1;
                    end
                end
            end

            DRAIN: begin
                busy_d = 1'b1;
                if (dcnt == D_LAST) begin
                    tile_done_d = 1'b1;
                    dcnt_d      = '0;
                    if (column == T_LAST) begin
                        col_d = '0;
                        if (tile_row == T_LAST) begin
                            trow_d  = '0;
                            state_d = DONE;
                        end else begin
                            trow_d  = tile_row + 1'b1;
                            state_d = FEED;
                        end
                    end else begin
                        col_d   = column + 1'b1;
                        state_d = FEED;
                    end
                end else begin
                    dcnt_d = dcnt + 1'b1;
                end
            end

            DONE: begin
                done_d  = 1'b1;
                k_d     = '0;
                dcnt_d  = '0;
                row_d   = '0;
                col_d   = '0;
                trow_d  = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_os_feed_ctrl.sv
// tb/tb_os_feed_ctrl.sv - scoreboard bench for os_feed_ctrl
module tb_os_feed_ctrl;

    localparam int D_W = 8;
    localparam int N   = 3;
    localparam int M   = 6;
    localparam int K_W = $clog2(M);
    localparam int T_W = $clog2(M / N);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           stall = 1'b0;
    logic [K_W-1:0] row;
    logic [T_W-1:0] column;
    logic           rd_en;
    logic           pe_init;
    logic [T_W-1:0] tile_row;
    logic           tile_done;
    logic           busy;
    logic           done;

    os_feed_ctrl #(.D_W(D_W), .N(N), .M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stall     (stall),
        .row       (row),
        .column    (column),
        .rd_en     (rd_en),
        .pe_init   (pe_init),
        .tile_row  (tile_row),
        .tile_done (tile_done),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int cyc;
        int k;
        int c;
        int tr;
    } rd_ev_t;

    rd_ev_t exp_rd[$];
    int     exp_td[$];
    int     exp_done[$];
    bit     stall_at[int];

    // Expected timeline of one run from the sampled-start edge t0, honouring stall_at.
    task automatic push_run(input int t0, output int done_cyc);
        int e;
        int td;
        e = t0 + 1;
        for (int tr = 0; tr < M / N; tr++) begin
            for (int c = 0; c < M / N; c++) begin
                for (int k = 0; k < M; k++) begin
                    while (stall_at.exists(e)) e++;
                    exp_rd.push_back('{cyc: e, k: k, c: c, tr: tr});
                    e++;
                end
                td = e - 1 + (2 * N - 1);
                exp_td.push_back(td);
                e = td + 1;
            end
        end
        exp_done.push_back(e);
        done_cyc = e;
    endtask

    // Drive inputs for the next edge, then return at the negedge after it.
    task automatic tick(input bit st);
        start = st;
        stall = stall_at.exists(cyc + 1);
        @(negedge clk);
    endtask

    // Scoreboard: pop and compare whenever the DUT produces an event.
    rd_ev_t ev;
    int     ecyc;
    always @(negedge clk) begin
        if (rd_en === 1'b1) begin
            n_vec++;
            if (exp_rd.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected cyc=%0d got row=%0d tile=(%0d,%0d) want no read",
                         cyc, row, tile_row, column);
            end else begin
                ev = exp_rd.pop_front();
                if (cyc != ev.cyc || row !== K_W'(ev.k) || column !== T_W'(ev.c) ||
                    tile_row !== T_W'(ev.tr) || pe_init !== (ev.k == 0)) begin
                    n_err++;
                    $display("FAIL rd_issue got cyc=%0d row=%0d tile=(%0d,%0d) pe_init=%0b want cyc=%0d row=%0d tile=(%0d,%0d) pe_init=%0b",
                             cyc, row, tile_row, column, pe_init, ev.cyc, ev.k, ev.tr, ev.c, ev.k == 0);
                end
            end
        end
        if (pe_init === 1'b1 && rd_en !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL pe_init_alone cyc=%0d got pe_init=1 rd_en=%b want rd_en=1", cyc, rd_en);
        end
        if (tile_done === 1'b1) begin
            n_vec++;
            if (exp_td.size() == 0) begin
                n_err++;
                $display("FAIL tile_done_unexpected cyc=%0d got 1 want 0", cyc);
            end else begin
                ecyc = exp_td.pop_front();
                if (cyc != ecyc) begin
                    n_err++;
                    $display("FAIL tile_done_cycle got %0d want %0d", cyc, ecyc);
                end
            end
        end
        if (done === 1'b1) begin
            n_vec++;
            if (exp_done.size() == 0) begin
                n_err++;
                $display("FAIL done_unexpected cyc=%0d got 1 want 0", cyc);
            end else begin
                ecyc = exp_done.pop_front();
                if (cyc != ecyc || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_cycle got cyc=%0d busy=%b want cyc=%0d busy=0", cyc, busy, ecyc);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        tick(1'b0);
        tick(1'b0);
        n_vec++;
        if ({row, column, rd_en, pe_init, tile_row, tile_done, busy, done} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got %b want all 0",
                     {row, column, rd_en, pe_init, tile_row, tile_done, busy, done});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            n_vec++;
            if ({row, column, rd_en, pe_init, tile_row, tile_done, busy, done} !== '0) begin
                n_err++;
                $display("FAIL idle_quiet cyc=%0d got %b want all 0", cyc,
                         {row, column, rd_en, pe_init, tile_row, tile_done, busy, done});
            end
        end
    endtask

    task automatic test_single_run();
        int t0;
        int dc;
        t0 = cyc + 1;
        push_run(t0, dc);
        tick(1'b1);
        n_vec++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL t0_outputs got busy=%b rd_en=%b want 0 0", busy, rd_en);
        end
        while (cyc < dc + 2) begin
            tick(1'b0);
            if (cyc == t0 + 1 || cyc == t0 + 44) begin
                n_vec++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_high cyc=t0+%0d got %b want 1", cyc - t0, busy);
                end
            end
            if (cyc > t0 && cyc <= t0 + 44 && (cyc - t0) % 11 == 0) begin
                n_vec++;
                if (tile_done !== 1'b1) begin
                    n_err++;
                    $display("FAIL tile_done_fixed cyc=t0+%0d got %b want 1", cyc - t0, tile_done);
                end
            end
            if (cyc == t0 + 45) begin
                n_vec++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_fixed cyc=t0+45 got done=%b busy=%b want 1 0", done, busy);
                end
            end
        end
        n_vec++;
        if (exp_rd.size() + exp_td.size() + exp_done.size() != 0) begin
            n_err++;
            $display("FAIL single_sb_left got %0d pending want 0",
                     exp_rd.size() + exp_td.size() + exp_done.size());
        end
    endtask

    task automatic test_stall_feed();
        int t0;
        int dc;
        t0 = cyc + 1;
        stall_at[t0 + 4] = 1'b1;
        stall_at[t0 + 5] = 1'b1;
        push_run(t0, dc);
        tick(1'b1);
        while (cyc < dc + 2) begin
            tick(1'b0);
            if (cyc == t0 + 4 || cyc == t0 + 5) begin
                n_vec++;
                if (rd_en !== 1'b0 || row !== K_W'(3)) begin
                    n_err++;
                    $display("FAIL stall_hold cyc=t0+%0d got rd_en=%b row=%0d want 0 3",
                             cyc - t0, rd_en, row);
                end
            end
            if (cyc == t0 + 13) begin
                n_vec++;
                if (tile_done !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_tile_done cyc=t0+13 got %b want 1", tile_done);
                end
            end
        end
        stall_at.delete();
        n_vec++;
        if (exp_rd.size() + exp_td.size() + exp_done.size() != 0) begin
            n_err++;
            $display("FAIL stall_sb_left got %0d pending want 0",
                     exp_rd.size() + exp_td.size() + exp_done.size());
        end
    endtask

    task automatic test_stall_drain_k0();
        int t0;
        int dc;
        t0 = cyc + 1;
        stall_at[t0 + 1]  = 1'b1;
        stall_at[t0 + 9]  = 1'b1;
        stall_at[t0 + 10] = 1'b1;
        push_run(t0, dc);
        tick(1'b1);
        while (cyc < dc + 2) begin
            tick(1'b0);
            if (cyc == t0 + 1) begin
                n_vec++;
                if (rd_en !== 1'b0 || pe_init !== 1'b0) begin
                    n_err++;
                    $display("FAIL k0_stall got rd_en=%b pe_init=%b want 0 0", rd_en, pe_init);
                end
            end
            if (cyc == t0 + 2) begin
                n_vec++;
                if (rd_en !== 1'b1 || pe_init !== 1'b1 || row !== '0) begin
                    n_err++;
                    $display("FAIL k0_deferred got rd_en=%b pe_init=%b row=%0d want 1 1 0",
                             rd_en, pe_init, row);
                end
            end
            if (cyc == t0 + 12) begin
                n_vec++;
                if (tile_done !== 1'b1) begin
                    n_err++;
                    $display("FAIL drain_stall_tile_done cyc=t0+12 got %b want 1", tile_done);
                end
            end
        end
        stall_at.delete();
        n_vec++;
        if (exp_rd.size() + exp_td.size() + exp_done.size() != 0) begin
            n_err++;
            $display("FAIL drain_sb_left got %0d pending want 0",
                     exp_rd.size() + exp_td.size() + exp_done.size());
        end
    endtask

    task automatic test_reset_midrun();
        int t0;
        int dc;
        t0 = cyc + 1;
        push_run(t0, dc);
        tick(1'b1);
        while (cyc < t0 + 14) tick(1'b0);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL midrun_busy got %b want 1", busy);
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({row, column, rd_en, pe_init, tile_row, tile_done, busy, done} !== '0) begin
            n_err++;
            $display("FAIL async_reset got %b want all 0",
                     {row, column, rd_en, pe_init, tile_row, tile_done, busy, done});
        end
        exp_rd.delete();
        exp_td.delete();
        exp_done.delete();
        for (int i = 0; i < 3; i++) tick(1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            n_vec++;
            if ({row, column, rd_en, pe_init, tile_row, tile_done, busy, done} !== '0) begin
                n_err++;
                $display("FAIL post_reset_idle got %b want all 0",
                         {row, column, rd_en, pe_init, tile_row, tile_done, busy, done});
            end
        end
        t0 = cyc + 1;
        push_run(t0, dc);
        tick(1'b1);
        while (cyc < dc + 2) tick(1'b0);
        n_vec++;
        if (exp_rd.size() + exp_td.size() + exp_done.size() != 0) begin
            n_err++;
            $display("FAIL rerun_sb_left got %0d pending want 0",
                     exp_rd.size() + exp_td.size() + exp_done.size());
        end
    endtask

    task automatic test_start_ignored();
        int t0;
        int dc;
        int t1;
        int dc1;
        t0 = cyc + 1;
        push_run(t0, dc);
        tick(1'b1);
        while (cyc < dc + 3) begin
            tick((cyc + 1 == t0 + 5) || (cyc + 1 == t0 + 20) || (cyc + 1 == dc));
            if (cyc == dc + 1 || cyc == dc + 2) begin
                n_vec++;
                if (busy !== 1'b0 || rd_en !== 1'b0) begin
                    n_err++;
                    $display("FAIL start_in_done cyc=done+%0d got busy=%b rd_en=%b want 0 0",
                             cyc - dc, busy, rd_en);
                end
            end
        end
        t1 = cyc + 1;
        push_run(t1, dc1);
        tick(1'b1);
        while (cyc < dc1 + 2) begin
            tick(1'b0);
            if (cyc == t1 + 1) begin
                n_vec++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL restart_busy got %b want 1", busy);
                end
            end
        end
        n_vec++;
        if (exp_rd.size() + exp_td.size() + exp_done.size() != 0) begin
            n_err++;
            $display("FAIL restart_sb_left got %0d pending want 0",
                     exp_rd.size() + exp_td.size() + exp_done.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_run();
        test_stall_feed();
        test_stall_drain_k0();
        test_reset_midrun();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
